// File: rtl/start_arith_engine_pkg.sv
// rtl/start_arith_engine_pkg.sv - shared types for the start-triggered arithmetic engine
// Contents: op_e (operation codes), state_e (FSM encoding), acc_width() helper.
package start_arith_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    MUL = 2'b01,
    MAC = 2'b10,
    CLR = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    DONE = 2'b10
  } state_e;

  // Accumulator width: full product plus guard bits.
  function automatic int acc_width(input int width, input int guard);
    return 2 * width + guard;
  endfunction

endpackage

// File: rtl/start_arith_engine_if.sv
// rtl/start_arith_engine_if.sv - request/response bundle for start_arith_engine
// master: drives start, op, a, b; observes busy, done, result, acc, ovf, err.
// slave : the engine side of the same signals.
interface start_arith_engine_if
  import start_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
);
  localparam int ACC_W = acc_width(WIDTH, GUARD);

  logic                 start;
  op_e                  op;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic [ACC_W-1:0]     acc;
  logic                 ovf;
  logic                 err;

  modport master (
    output start, op, a, b,
    input  busy, done, result, acc, ovf, err
  );

  modport slave (
    input  start, op, a, b,
    output busy, done, result, acc, ovf, err
  );
endinterface

// File: rtl/start_arith_engine_seq_mult.sv
// rtl/start_arith_engine_seq_mult.sv - LSB-first shift-add multiplier, one step per cycle
// Ports: clk, rst_n (async low); load latches a/b and starts WIDTH steps;
// last flags the final step; product_next is the partial product after the current step.
module seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 load,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 last,
  output logic [2*WIDTH-1:0]   product_next
);
  localparam int CNT_W = $clog2(WIDTH);

  logic [2*WIDTH-1:0] mcand;
  logic [2*WIDTH-1:0] pp;
  logic [WIDTH-1:0]   mplier;
  logic [CNT_W-1:0]   cnt;
  logic               active;

  assign last         = active && (cnt == CNT_W'(WIDTH - 1));
  // Exposed combinationally so the caller can capture the full product on the last step.
  assign product_next = pp + (mplier[0] ? mcand : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      pp     <= '0;
      mplier <= '0;
      cnt    <= '0;
      active <= 1'b0;
    end else if (load) begin
      mcand  <= {{WIDTH{1'b0}}, a};
      mplier <= b;
      pp     <= '0;
      cnt    <= '0;
      active <= 1'b1;
    end else if (active) begin
      pp     <= product_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= cnt + 1'b1;
      if (last) active <= 1'b0;
    end
  end
endmodule

// File: rtl/start_arith_engine.sv
// rtl/start_arith_engine.sv - start-edge triggered ADD/MUL/MAC/CLR engine with accumulator
// Ports: clk, rst_n (async low), bus (slave): start/op/a/b in; busy/done/result/acc/ovf/err out.
// ADD and CLR finish on the launching edge; MUL/MAC take WIDTH cycles in seq_mult.
module start_arith_engine
  import start_arith_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int GUARD = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  start_arith_engine_if.slave  bus
);
  localparam int ACC_W = acc_width(WIDTH, GUARD);

  localparam logic [1:0] ST_IDLE = IDLE;
  localparam logic [1:0] ST_CALC = CALC;
  localparam logic [1:0] ST_DONE = DONE;

  logic [1:0]         state;
  logic               start_q;
  logic               rise;
  op_e                op_q;
  logic [2*WIDTH-1:0] result;
  logic [ACC_W-1:0]   acc;
  logic               ovf;
  logic               err;

  logic               mult_load;
  logic               mult_last;
  logic [2*WIDTH-1:0] product_next;
  logic [ACC_W:0]     acc_sum;
  logic [WIDTH:0]     add_sum;

  assign rise      = bus.start & ~start_q;
  assign mult_load = (state == ST_IDLE) && rise && ((bus.op == MUL) || (bus.op == MAC));
  assign add_sum   = {1'b0, bus.a} + {1'b0, bus.b};
  // One extra bit on top catches the wrap out of the accumulator.
  assign acc_sum   = {1'b0, acc} + {{(ACC_W + 1 - 2*WIDTH){1'b0}}, product_next};

  seq_mult #(.WIDTH(WIDTH)) u_mult (
    .clk          (clk),
    .rst_n        (rst_n),
    .load         (mult_load),
    .a            (bus.a),
    .b            (bus.b),
    .last         (mult_last),
    .product_next (product_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      start_q <= 1'b0;
      op_q    <= ADD;
      result  <= '0;
      acc     <= '0;
      ovf     <= 1'b0;
      err     <= 1'b0;
    end else begin
      start_q <= bus.start;
      // Any rise outside IDLE, including the DONE->IDLE edge, is refused.
      err     <= rise && (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (rise) begin
            case (bus.op)
              ADD: begin
                result <= {{(WIDTH-1){1'b0}}, add_sum};
                state  <= ST_DONE;
              end
              CLR: begin
                acc   <= '0;
                ovf   <= 1'b0;
                state <= ST_DONE;
              end
              default: begin
                op_q  <= bus.op;
                state <= ST_CALC;
              end
            endcase
          end
        end
        ST_CALC: begin
          if (mult_last) begin
            result <= product_next;
            if (op_q == MAC) begin
              acc <= acc_sum[ACC_W-1:0];
              if (acc_sum[ACC_W]) ovf <= 1'b1;
            end
            state <= ST_DONE;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy   = (state == ST_CALC);
  assign bus.done   = (state == ST_DONE);
  assign bus.result = result;
  assign bus.acc    = acc;
  assign bus.ovf    = ovf;
  assign bus.err    = err;
endmodule

// File: tb/tb_start_arith_engine.sv
// tb/tb_start_arith_engine.sv - directed self-checking bench for start_arith_engine
module tb_start_arith_engine;
  import start_arith_pkg::*;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;

  start_arith_engine_if #(.WIDTH(8), .GUARD(4)) ifc ();
  start_arith_engine_if #(.WIDTH(8), .GUARD(0)) ifz ();

  start_arith_engine #(.WIDTH(8), .GUARD(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  start_arith_engine #(.WIDTH(8), .GUARD(0)) dut_g0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Launch a MUL/MAC on the GUARD=4 engine and follow it to completion.
  task automatic do_mul(input op_e o, input logic [7:0] x, input logic [7:0] y,
                        input logic [15:0] exp_res, input string tag);
    int bc;
    ifc.op = o; ifc.a = x; ifc.b = y; ifc.start = 1'b1;
    tick();
    chk({tag, " busy_after_launch"}, ifc.busy, 1);
    ifc.start = 1'b0; ifc.a = ~x; ifc.b = ~y;
    bc = 1;
    repeat (7) begin
      tick();
      bc += int'(ifc.busy);
    end
    chk({tag, " busy_cycles"}, bc, 8);
    chk({tag, " done_early"}, ifc.done, 0);
    tick();
    chk({tag, " done"}, ifc.done, 1);
    chk({tag, " busy_in_done"}, ifc.busy, 0);
    chk({tag, " result"}, ifc.result, exp_res);
    tick();
    chk({tag, " done_one_cycle"}, ifc.done, 0);
  endtask

  // Run one operation on the GUARD=0 engine; done is up WIDTH edges after a MUL/MAC launch.
  task automatic run_g0(input op_e o, input logic [7:0] x, input logic [7:0] y);
    ifz.op = o; ifz.a = x; ifz.b = y; ifz.start = 1'b1;
    tick();
    ifz.start = 1'b0;
    if (o == MUL || o == MAC) repeat (8) tick();
    chk("g0 done", ifz.done, 1);
    tick();
  endtask

  initial begin
    int dc;
    int ec;
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    ifc.start = 1'b0; ifc.op = ADD; ifc.a = '0; ifc.b = '0;
    ifz.start = 1'b0; ifz.op = ADD; ifz.a = '0; ifz.b = '0;

    // Reset state
    repeat (2) tick();
    chk("rst busy", ifc.busy, 0);
    chk("rst done", ifc.done, 0);
    chk("rst err", ifc.err, 0);
    chk("rst result", ifc.result, 0);
    chk("rst acc", ifc.acc, 0);
    chk("rst ovf", ifc.ovf, 0);
    rst_n = 1'b1;
    tick();

    // ADD 5+8
    ifc.op = ADD; ifc.a = 8'd5; ifc.b = 8'd8; ifc.start = 1'b1;
    tick();
    chk("add done", ifc.done, 1);
    chk("add result", ifc.result, 13);
    chk("add busy", ifc.busy, 0);
    ifc.start = 1'b0;
    tick();
    chk("add done_clear", ifc.done, 0);
    chk("add busy_after", ifc.busy, 0);

    // ADD carry out: 255+255 needs WIDTH+1 bits
    ifc.a = 8'd255; ifc.b = 8'd255; ifc.start = 1'b1;
    tick();
    chk("add carry result", ifc.result, 510);
    ifc.start = 1'b0;
    tick();

    do_mul(MUL, 8'd9, 8'd7, 16'd63, "mul9x7");
    chk("mul acc untouched", ifc.acc, 0);
    do_mul(MUL, 8'd255, 8'd255, 16'd65025, "mul255");

    // Second rise during CALC, then a rise on the DONE->IDLE edge
    ifc.op = MUL; ifc.a = 8'd9; ifc.b = 8'd7; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    tick();
    tick();
    ifc.start = 1'b1;
    tick();
    chk("calc_rise err", ifc.err, 1);
    chk("calc_rise busy", ifc.busy, 1);
    ifc.start = 1'b0;
    tick();
    chk("calc_rise err_one_cycle", ifc.err, 0);
    repeat (3) tick();
    chk("calc_rise done_early", ifc.done, 0);
    chk("calc_rise result_held", ifc.result, 65025);
    tick();
    chk("calc_rise done", ifc.done, 1);
    chk("calc_rise result", ifc.result, 63);
    ifc.op = ADD; ifc.a = 8'd1; ifc.b = 8'd1; ifc.start = 1'b1;
    tick();
    chk("done_rise err", ifc.err, 1);
    chk("done_rise done", ifc.done, 0);
    ifc.start = 1'b0;
    dc = 0;
    repeat (4) begin
      tick();
      dc += int'(ifc.done) + int'(ifc.busy);
    end
    chk("done_rise no_launch", dc, 0);
    chk("done_rise result", ifc.result, 63);

    // CLR then MAC chain
    ifc.op = CLR; ifc.start = 1'b1;
    tick();
    chk("clr done", ifc.done, 1);
    chk("clr acc", ifc.acc, 0);
    chk("clr result_held", ifc.result, 63);
    ifc.start = 1'b0;
    tick();
    do_mul(MAC, 8'd5, 8'd8, 16'd40, "mac5x8");
    chk("mac5x8 acc", ifc.acc, 40);
    do_mul(MAC, 8'd9, 8'd7, 16'd63, "mac9x7");
    chk("mac9x7 acc", ifc.acc, 103);
    chk("mac9x7 ovf", ifc.ovf, 0);

    // Reset in the middle of a MAC
    ifc.op = MAC; ifc.a = 8'd9; ifc.b = 8'd7; ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    repeat (4) tick();
    rst_n = 1'b0;
    #1;
    chk("midrst busy", ifc.busy, 0);
    chk("midrst done", ifc.done, 0);
    chk("midrst err", ifc.err, 0);
    chk("midrst result", ifc.result, 0);
    chk("midrst acc", ifc.acc, 0);
    chk("midrst ovf", ifc.ovf, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    dc = 0;
    repeat (12) begin
      tick();
      dc += int'(ifc.done);
    end
    chk("midrst no_done", dc, 0);
    chk("midrst acc_after", ifc.acc, 0);

    // start held high for 20 cycles
    ifc.op = ADD; ifc.a = 8'd1; ifc.b = 8'd1; ifc.start = 1'b1;
    dc = 0;
    ec = 0;
    repeat (20) begin
      tick();
      dc += int'(ifc.done);
      ec += int'(ifc.err);
    end
    chk("held done_count", dc, 1);
    chk("held err_count", ec, 0);
    chk("held result", ifc.result, 2);
    ifc.start = 1'b0;
    tick();

    // GUARD=0 accumulator wrap
    run_g0(MAC, 8'd255, 8'd255);
    chk("g0 acc1", ifz.acc, 65025);
    chk("g0 ovf1", ifz.ovf, 0);
    run_g0(MAC, 8'd255, 8'd255);
    chk("g0 acc2", ifz.acc, 64514);
    chk("g0 ovf2", ifz.ovf, 1);
    run_g0(ADD, 8'd1, 8'd1);
    chk("g0 ovf_sticky", ifz.ovf, 1);
    run_g0(CLR, 8'd0, 8'd0);
    chk("g0 clr acc", ifz.acc, 0);
    chk("g0 clr ovf", ifz.ovf, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
